// File: rtl/bindec_issue_sched_pkg.sv
// rtl/bindec_issue_sched_pkg.sv - shared constants and types for the binDec issue scheduler
package bindec_ctl_pkg;

    localparam int BINDEC_LATENCY = 17;
    localparam int TAG_ID_W       = 2;
    localparam int TAG_SLOT_W     = 4;

    typedef enum logic [1:0] {
        _no_excpt_         = 2'd0,
        _underFlowExact_   = 2'd1,
        _underFlowInexact_ = 2'd2,
        _inexact_          = 2'd3
    } bindec_excpt_e;

    // Rides the completion delay line, one entry per issued operand.
    typedef struct packed {
        logic                  valid;
        logic [TAG_ID_W-1:0]   id;
        logic [TAG_SLOT_W-1:0] slot;
    } issue_tag_t;

endpackage

// File: rtl/bindec_issue_sched_if.sv
// rtl/bindec_issue_sched_if.sv - requester, operator and completion signals of the scheduler
interface bindec_issue_sched_if #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ADDRS_WIDTH = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*64-1:0] req_data;
    logic [NUM_REQ*2-1:0]  req_round_mode;
    logic [NUM_REQ-1:0]    req_away;
    logic [NUM_REQ-1:0]    gnt;
    logic                  op_wren;
    logic [ADDRS_WIDTH-1:0] op_wraddrs;
    logic [63:0]           op_wrdata;
    logic [1:0]            op_round_mode;
    logic                  op_away;
    logic                  cmp_valid;
    logic [ID_W-1:0]       cmp_id;
    logic [ADDRS_WIDTH-1:0] cmp_slot;
    logic                  rel_valid;
    logic [ADDRS_WIDTH-1:0] rel_slot;
    logic                  rel_err;
    logic [ADDRS_WIDTH:0]  in_flight;

    modport master (
        output req, req_data, req_round_mode, req_away, rel_valid, rel_slot,
        input  gnt, op_wren, op_wraddrs, op_wrdata, op_round_mode, op_away,
               cmp_valid, cmp_id, cmp_slot, rel_err, in_flight
    );

    modport slave (
        input  req, req_data, req_round_mode, req_away, rel_valid, rel_slot,
        output gnt, op_wren, op_wraddrs, op_wrdata, op_round_mode, op_away,
               cmp_valid, cmp_id, cmp_slot, rel_err, in_flight
    );
endinterface

// File: rtl/bindec_issue_sched_arb.sv
// rtl/bindec_issue_sched_arb.sv - round-robin arbiter, first request at or after ptr wins
module rr_arbiter_onehot #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    winner,
    output logic               any
);
    int best_off;

    // Distance from ptr (mod NUM_REQ) ranks requesters; the smallest distance wins.
    always_comb begin
        gnt      = '0;
        winner   = '0;
        any      = 1'b0;
        best_off = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && ((j - int'(ptr) + NUM_REQ) % NUM_REQ) < best_off) begin
                best_off = (j - int'(ptr) + NUM_REQ) % NUM_REQ;
                gnt      = '0;
                gnt[j]   = 1'b1;
                winner   = ID_W'(j);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bindec_issue_sched.sv
// rtl/bindec_issue_sched.sv - shares one binDec operator among requesters, tracks slots to completion
module bindec_issue_sched
    import bindec_ctl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = TAG_ID_W,
    parameter int SLOTS       = 16,
    parameter int ADDRS_WIDTH = TAG_SLOT_W,
    parameter int LATENCY     = BINDEC_LATENCY
) (
    input  logic                 CLK,
    input  logic                 RESET,
    bindec_issue_sched_if.slave  bus
);
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [ID_W-1:0]        winner;
    logic                   arb_any;
    logic [ADDRS_WIDTH-1:0] free_slot;
    logic                   free_any;
    logic                   accept;
    logic                   rel_ok;

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [SLOTS-1:0]       busy_q, busy_d, done_q, done_d;
    issue_tag_t             pipe_q [LATENCY+1];
    issue_tag_t             pipe_d [LATENCY+1];
    logic                   op_wren_q, op_wren_d;
    logic [ADDRS_WIDTH-1:0] op_wraddrs_q, op_wraddrs_d;
    logic [63:0]            op_wrdata_q, op_wrdata_d;
    logic [1:0]             op_round_mode_q, op_round_mode_d;
    logic                   op_away_q, op_away_d;
    logic                   cmp_valid_q, cmp_valid_d;
    logic [ID_W-1:0]        cmp_id_q, cmp_id_d;
    logic [ADDRS_WIDTH-1:0] cmp_slot_q, cmp_slot_d;
    logic                   rel_err_q, rel_err_d;
    logic [ADDRS_WIDTH:0]   in_flight_q, in_flight_d;

    rr_arbiter_onehot #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .winner (winner),
        .any    (arb_any)
    );

    always_comb begin
        free_slot = '0;
        free_any  = 1'b0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!busy_q[s]) begin
                free_slot = ADDRS_WIDTH'(s);
                free_any  = 1'b1;
            end
        end
    end

    // Released slots only become free at the next edge, so allocation sees busy_q alone.
    assign accept = arb_any & free_any & ~RESET;
    assign rel_ok = bus.rel_valid & busy_q[bus.rel_slot] & done_q[bus.rel_slot];
    assign bus.gnt = accept ? arb_gnt : '0;

    always_comb begin
        ptr_d           = ptr_q;
        busy_d          = busy_q;
        done_d          = done_q;
        op_wren_d       = accept;
        op_wraddrs_d    = op_wraddrs_q;
        op_wrdata_d     = op_wrdata_q;
        op_round_mode_d = op_round_mode_q;
        op_away_d       = op_away_q;
        if (accept) begin
            ptr_d             = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            busy_d[free_slot] = 1'b1;
            op_wraddrs_d      = free_slot;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (arb_gnt[j]) begin
                    op_wrdata_d     = bus.req_data[64*j +: 64];
                    op_round_mode_d = bus.req_round_mode[2*j +: 2];
                    op_away_d       = bus.req_away[j];
                end
            end
        end
        if (cmp_valid_q) begin
            done_d[cmp_slot_q] = 1'b1;
        end
        if (rel_ok) begin
            busy_d[bus.rel_slot] = 1'b0;
            done_d[bus.rel_slot] = 1'b0;
        end
        pipe_d[0].valid = accept;
        pipe_d[0].id    = TAG_ID_W'(winner);
        pipe_d[0].slot  = TAG_SLOT_W'(free_slot);
        for (int k = 1; k <= LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        cmp_valid_d = pipe_q[LATENCY].valid;
        cmp_id_d    = ID_W'(pipe_q[LATENCY].id);
        cmp_slot_d  = ADDRS_WIDTH'(pipe_q[LATENCY].slot);
        rel_err_d   = bus.rel_valid & ~rel_ok;
        in_flight_d = in_flight_q + (ADDRS_WIDTH+1)'(accept) - (ADDRS_WIDTH+1)'(rel_ok);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q           <= '0;
            busy_q          <= '0;
            done_q          <= '0;
            op_wren_q       <= 1'b0;
            op_wraddrs_q    <= '0;
            op_wrdata_q     <= '0;
            op_round_mode_q <= '0;
            op_away_q       <= 1'b0;
            cmp_valid_q     <= 1'b0;
            cmp_id_q        <= '0;
            cmp_slot_q      <= '0;
            rel_err_q       <= 1'b0;
            in_flight_q     <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            ptr_q           <= ptr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            op_wren_q       <= op_wren_d;
            op_wraddrs_q    <= op_wraddrs_d;
            op_wrdata_q     <= op_wrdata_d;
            op_round_mode_q <= op_round_mode_d;
            op_away_q       <= op_away_d;
            cmp_valid_q     <= cmp_valid_d;
            cmp_id_q        <= cmp_id_d;
            cmp_slot_q      <= cmp_slot_d;
            rel_err_q       <= rel_err_d;
            in_flight_q     <= in_flight_d;
            pipe_q          <= pipe_d;
        end
    end

    assign bus.op_wren       = op_wren_q;
    assign bus.op_wraddrs    = op_wraddrs_q;
    assign bus.op_wrdata     = op_wrdata_q;
    assign bus.op_round_mode = op_round_mode_q;
    assign bus.op_away       = op_away_q;
    assign bus.cmp_valid     = cmp_valid_q;
    assign bus.cmp_id        = cmp_id_q;
    assign bus.cmp_slot      = cmp_slot_q;
    assign bus.rel_err       = rel_err_q;
    assign bus.in_flight     = in_flight_q;
endmodule

// File: tb/tb_bindec_issue_sched.sv
// tb/tb_bindec_issue_sched.sv - scoreboard bench for the binDec issue scheduler
module tb_bindec_issue_sched;
    localparam int CMP_DLY = 19;

    typedef struct {
        int cyc;
        int id;
        int slot;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n0;

    exp_t iss_q[$];
    exp_t cmp_q[$];
    int   rerr_q[$];

    logic [63:0] DATA [4];
    logic [1:0]  MODE [4];
    logic        AWAY [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bindec_issue_sched_if #(.NUM_REQ(4), .ID_W(2), .ADDRS_WIDTH(4)) bus ();

    bindec_issue_sched #(
        .NUM_REQ(4), .ID_W(2), .SLOTS(16), .ADDRS_WIDTH(4), .LATENCY(17)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.rel_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_iss(input int c, input int id, input int slot);
        exp_t e;
        e.cyc = c; e.id = id; e.slot = slot;
        iss_q.push_back(e);
    endtask

    task automatic push_cmp(input int c, input int id, input int slot);
        exp_t e;
        e.cyc = c; e.id = id; e.slot = slot;
        cmp_q.push_back(e);
    endtask

    // Called at the negedge of the accept cycle.
    task automatic expect_accept(input int id, input int slot);
        chk("gnt", bus.gnt, 64'(1 << id));
        push_iss(cyc + 1, id, slot);
        push_cmp(cyc + CMP_DLY, id, slot);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (bus.op_wren === 1'b1) begin
            if (iss_q.size() == 0) chk("spurious_issue", bus.op_wren, 0);
            else begin
                e = iss_q.pop_front();
                chk("iss_cycle", cyc, e.cyc);
                chk("iss_slot", bus.op_wraddrs, e.slot);
                chk("iss_data", bus.op_wrdata, DATA[e.id]);
                chk("iss_mode", bus.op_round_mode, MODE[e.id]);
                chk("iss_away", bus.op_away, AWAY[e.id]);
            end
        end
        if (bus.cmp_valid === 1'b1) begin
            if (cmp_q.size() == 0) chk("spurious_cmp", bus.cmp_valid, 0);
            else begin
                e = cmp_q.pop_front();
                chk("cmp_cycle", cyc, e.cyc);
                chk("cmp_id", bus.cmp_id, e.id);
                chk("cmp_slot", bus.cmp_slot, e.slot);
            end
        end
        if (bus.rel_err === 1'b1) begin
            if (rerr_q.size() == 0) chk("spurious_rel_err", bus.rel_err, 0);
            else begin
                c = rerr_q.pop_front();
                chk("rel_err_cycle", cyc, c);
            end
        end
    end

    initial begin
        DATA[0] = 64'h3FF0000000000000; MODE[0] = 2'd0; AWAY[0] = 1'b0;
        DATA[1] = 64'h4000000000000000; MODE[1] = 2'd1; AWAY[1] = 1'b1;
        DATA[2] = 64'h4059000000000000; MODE[2] = 2'd2; AWAY[2] = 1'b0;
        DATA[3] = 64'hBFF8000000000000; MODE[3] = 2'd3; AWAY[3] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.req_data[64*j +: 64]     = DATA[j];
            bus.req_round_mode[2*j +: 2] = MODE[j];
            bus.req_away[j]              = AWAY[j];
        end
        bus.rel_slot  = '0;
        bus.rel_valid = 1'b0;

        // Reset with every request raised: nothing may be granted.
        rst = 1'b1;
        bus.req = 4'b1111;
        step();
        @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_op_wren", bus.op_wren, 0);
        chk("rst_op_wraddrs", bus.op_wraddrs, 0);
        chk("rst_cmp_valid", bus.cmp_valid, 0);
        chk("rst_cmp_id", bus.cmp_id, 0);
        chk("rst_rel_err", bus.rel_err, 0);
        chk("rst_in_flight", bus.in_flight, 0);
        do_reset();

        // Single op from requester 0.
        bus.req = 4'b0001;
        @(negedge clk);
        expect_accept(0, 0);
        step();
        bus.req = '0;
        repeat (20) step();
        @(negedge clk);
        chk("single_in_flight", bus.in_flight, 1);
        bus.rel_valid = 1'b1;
        bus.rel_slot  = 4'd0;
        step();
        bus.rel_valid = 1'b0;
        @(negedge clk);
        chk("single_released", bus.in_flight, 0);

        // Round robin with all requesters held.
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            expect_accept(i % 4, i);
            step();
        end
        bus.req = '0;
        @(negedge clk);
        chk("rr_in_flight", bus.in_flight, 8);
        repeat (22) step();

        // Fill all slots, then free slot 5 while requester 0 keeps asking.
        do_reset();
        bus.req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            expect_accept(0, i);
            step();
        end
        @(negedge clk);
        chk("full_gnt", bus.gnt, 0);
        chk("full_in_flight", bus.in_flight, 16);
        repeat (20) step();
        bus.rel_valid = 1'b1;
        bus.rel_slot  = 4'd5;
        @(negedge clk);
        chk("rel_cycle_gnt", bus.gnt, 0);
        chk("rel_cycle_in_flight", bus.in_flight, 16);
        step();
        bus.rel_valid = 1'b0;
        @(negedge clk);
        expect_accept(0, 5);
        chk("after_rel_in_flight", bus.in_flight, 15);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("refill_in_flight", bus.in_flight, 16);
        repeat (22) step();

        // Illegal releases: busy-not-done, free, and same cycle as completion.
        do_reset();
        n0 = cyc;
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_accept(0, i);
            step();
        end
        bus.req = '0;
        bus.rel_valid = 1'b1;
        bus.rel_slot  = 4'd3;
        @(negedge clk);
        rerr_q.push_back(cyc + 1);
        step();
        bus.rel_slot = 4'd9;
        @(negedge clk);
        rerr_q.push_back(cyc + 1);
        step();
        bus.rel_valid = 1'b0;
        @(negedge clk);
        chk("illegal_in_flight", bus.in_flight, 4);
        while (cyc < n0 + CMP_DLY) step();
        bus.rel_valid = 1'b1;
        bus.rel_slot  = 4'd0;
        @(negedge clk);
        rerr_q.push_back(cyc + 1);
        step();
        step();
        bus.rel_valid = 1'b0;
        @(negedge clk);
        chk("legal_rel_in_flight", bus.in_flight, 3);
        repeat (6) step();

        // Reset five cycles after an issue drops the in-flight tag.
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        chk("midrst_gnt", bus.gnt, 64'h2);
        push_iss(cyc + 1, 1, 0);
        step();
        bus.req = '0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (25) step();
        @(negedge clk);
        chk("midrst_in_flight", bus.in_flight, 0);
        step();
        bus.req = 4'b1111;
        @(negedge clk);
        expect_accept(0, 0);
        step();
        bus.req = '0;
        repeat (22) step();

        @(negedge clk);
        chk("iss_left", iss_q.size(), 0);
        chk("cmp_left", cmp_q.size(), 0);
        chk("rel_err_left", rerr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
